// File: rtl/pll_trim_controller_if.sv
// ----------------------------------------------------------------------------
// pll_trim_controller_if
//   Groups the oscillator-facing signals of the PLL trim controller.
//   osc  : ring-oscillator output, asynchronous to the reference clock
//   div  : target reference-clock cycles per full oscillator period
//   trim : 26-bit thermometer trim code back to the oscillator delay cells
//   master : the side that owns the oscillator and programs div
//   slave  : the trim controller
// ----------------------------------------------------------------------------
interface pll_trim_controller_if;
    logic        osc;
    logic [4:0]  div;
    logic [25:0] trim;

    modport master (
        output osc,
        output div,
        input  trim
    );

    modport slave (
        input  osc,
        input  div,
        output trim
    );
endinterface

// File: rtl/pll_trim_controller.sv
// ----------------------------------------------------------------------------
// pll_trim_controller
//   Digital loop controller for a ring-oscillator PLL. Measures each
//   oscillator half-period in reference clocks, compares the last full period
//   with the programmed div and nudges a 7-bit trim accumulator by one per
//   oscillator edge. The accumulator's upper five bits drive a thermometer
//   trim code.
// Ports
//   clock : reference clock, all state updates on its rising edge
//   reset : asynchronous active-low reset, clears all state
//   bus   : slave modport (osc, div in; trim out)
// ----------------------------------------------------------------------------
module pll_trim_controller (
    input  logic                          clock,
    input  logic                          reset,
    pll_trim_controller_if.slave          bus
);

    logic [2:0]  r_oscbuf;   // [0],[1] synchronise osc, [2] is the edge-detect delay
    logic [4:0]  r_count0;   // clocks in the current half-period
    logic [4:0]  r_count1;   // clocks in the previous half-period
    logic [2:0]  r_prep;     // warm-up: all ones once three edges have been seen
    logic [6:0]  r_tval;     // trim accumulator

    logic        w_edge;
    logic [5:0]  w_sum;
    logic [5:0]  w_div_ext;
    logic [6:0]  w_tval_next;

    // Thermometer code: the lowest tint bits set, saturating at all 26 ones.
    function automatic logic [25:0] therm_code(input logic [4:0] tint);
        logic [25:0] code;
        code = 26'd0;
        for (int i = 0; i < 26; i++) begin
            code[i] = (i < int'(tint));
        end
        return code;
    endfunction

    // Both osc polarities produce an event, i.e. one per half-period.
    assign w_edge    = r_oscbuf[2] ^ r_oscbuf[1];
    assign w_sum     = {1'b0, r_count0} + {1'b0, r_count1};
    assign w_div_ext = {1'b0, bus.div};

    // Next accumulator value: only moves on an edge once warm-up has finished.
    always_comb begin
        w_tval_next = r_tval;
        if (w_edge && (r_prep == 3'b111)) begin
            if (w_sum > w_div_ext) begin
                // Period too long: oscillator too slow, speed it up.
                if (r_tval != 7'd127) begin
                    w_tval_next = r_tval + 7'd1;
                end else begin
                    w_tval_next = r_tval;
                end
            end else if (w_sum < w_div_ext) begin
                if (r_tval != 7'd0) begin
                    w_tval_next = r_tval - 7'd1;
                end else begin
                    w_tval_next = r_tval;
                end
            end else begin
                w_tval_next = r_tval;
            end
        end else begin
            w_tval_next = r_tval;
        end
    end

    // Synchroniser, half-period counters, warm-up and accumulator state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_oscbuf <= 3'd0;
            r_count0 <= 5'd0;
            r_count1 <= 5'd0;
            r_prep   <= 3'd0;
            r_tval   <= 7'd0;
        end else begin
            r_oscbuf <= {r_oscbuf[1:0], bus.osc};
            r_tval   <= w_tval_next;
            if (w_edge) begin
                r_count1 <= r_count0;
                r_count0 <= 5'd1;
                r_prep   <= {r_prep[1:0], 1'b1};
            end else begin
                // Saturate so a stalled oscillator reads as "very slow".
                if (r_count0 != 5'd31) begin
                    r_count0 <= r_count0 + 5'd1;
                end else begin
                    r_count0 <= r_count0;
                end
            end
        end
    end

    // tval[1:0] is hysteresis only; the trim code follows tval[6:2].
    assign bus.trim = therm_code(r_tval[6:2]);

endmodule

// File: tb/tb_pll_trim_controller.sv
// ----------------------------------------------------------------------------
// tb_pll_trim_controller
//   Directed bench for pll_trim_controller. The stimulus process drives the
//   oscillator half-period by half-period and queues hand-computed expected
//   accumulator/trim values; a monitor process pops and compares them on the
//   falling clock edge and also checks the trim mapping every cycle.
// ----------------------------------------------------------------------------
module tb_pll_trim_controller;

    logic clock;
    logic reset;

    pll_trim_controller_if bus_if ();

    pll_trim_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        string       name;
        logic [6:0]  tval;
        logic [25:0] trim;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference mapping: (1 << min(tval>>2, 26)) - 1
    function automatic logic [25:0] ref_trim(input logic [6:0] tv);
        logic [26:0] one;
        logic [26:0] tmp;
        int          n;
        n   = int'(tv >> 2);
        if (n > 26) n = 26;
        one = 27'd1;
        tmp = (one << n) - 27'd1;
        return tmp[25:0];
    endfunction

    task automatic push_check(input string name, input logic [6:0] tv, input logic [25:0] tr);
        chk_t e;
        e.name = name;
        e.tval = tv;
        e.trim = tr;
        sb_q.push_back(e);
    endtask

    // One oscillator half-period of four reference clocks; the edge is
    // absorbed by the third rising clock after the toggle.
    task automatic osc_half();
        #2 bus_if.osc = ~bus_if.osc;
        repeat (4) @(posedge clock);
    endtask

    task automatic run_halves(input int n);
        for (int i = 0; i < n; i++) osc_half();
    endtask

    // Monitor: mapping invariant every cycle, then drain the scoreboard.
    initial begin
        chk_t e;
        forever begin
            @(negedge clock);
            n_checks++;
            if (bus_if.trim !== ref_trim(dut.r_tval)) begin
                n_errors++;
                $display("FAIL map t=%0t tval=%0d trim=%h expected %h",
                         $time, dut.r_tval, bus_if.trim, ref_trim(dut.r_tval));
            end
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (dut.r_tval !== e.tval || bus_if.trim !== e.trim) begin
                    n_errors++;
                    $display("FAIL %s t=%0t tval=%0d trim=%h expected tval=%0d trim=%h",
                             e.name, $time, dut.r_tval, bus_if.trim, e.tval, e.trim);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t stimulus did not complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        bus_if.osc = 1'b0;
        bus_if.div = 5'd2;
        push_check("reset_state", 7'd0, 26'h0);
        #20 reset = 1'b1;

        // Warm-up: three edges leave tval at 0, the fourth increments.
        osc_half(); push_check("warmup_e1", 7'd0, 26'h0);
        osc_half(); push_check("warmup_e2", 7'd0, 26'h0);
        osc_half(); push_check("warmup_e3", 7'd0, 26'h0);
        osc_half(); push_check("warmup_e4", 7'd1, 26'h0);
        osc_half(); push_check("ramp_e5",   7'd2, 26'h0);

        // Saturation high: 140 edges total, 137 past warm-up.
        run_halves(135); push_check("sat_high",      7'd127, 26'h3FFFFFF);
        run_halves(10);  push_check("sat_high_hold", 7'd127, 26'h3FFFFFF);

        // Saturation low with sum = 8 < 31.
        bus_if.div = 5'd31;
        run_halves(5);   push_check("dec_5",        7'd122, 26'h3FFFFFF);
        run_halves(130); push_check("sat_low",      7'd0,   26'h0);
        run_halves(5);   push_check("sat_low_hold", 7'd0,   26'h0);

        // Lock behaviour around sum = 8.
        bus_if.div = 5'd7;
        run_halves(10);  push_check("div7_inc",  7'd10, 26'h3);
        bus_if.div = 5'd8;
        run_halves(5);   push_check("div8_lock", 7'd10, 26'h3);
        bus_if.div = 5'd7;
        run_halves(3);   push_check("div7_inc2", 7'd13, 26'h7);
        bus_if.div = 5'd9;
        run_halves(5);   push_check("div9_dec",  7'd8,  26'h3);

        // Climb to 60, then assert reset between clock edges.
        bus_if.div = 5'd2;
        run_halves(52);  push_check("tval_60", 7'd60, 26'h7FFF);
        @(posedge clock);
        #3 reset = 1'b0;
        push_check("async_reset", 7'd0, 26'h0);
        bus_if.osc = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        osc_half(); push_check("rewarm_e1", 7'd0, 26'h0);
        osc_half(); push_check("rewarm_e2", 7'd0, 26'h0);
        osc_half(); push_check("rewarm_e3", 7'd0, 26'h0);
        osc_half(); push_check("rewarm_e4", 7'd1, 26'h0);

        // Stalled oscillator: count0 saturates at 31, so sum = 35 > 31.
        bus_if.div = 5'd31;
        repeat (44) @(posedge clock);
        push_check("stall_hold", 7'd1, 26'h0);
        osc_half(); push_check("after_stall", 7'd2, 26'h0);
        osc_half(); push_check("after_stall2", 7'd3, 26'h0);

        // div = 0: every nonzero sum increments.
        bus_if.div = 5'd0;
        run_halves(2);   push_check("div0_inc", 7'd5, 26'h1);

        repeat (3) @(negedge clock);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
